// File: rtl/l2_pkg.sv
// Shared types and default geometry for the L2 instruction-fetch responder.
package l2_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned BLOCK_W = 256;
    localparam int unsigned MEM_W   = 32;
    localparam int unsigned BEATS   = BLOCK_W / MEM_W;
    localparam int unsigned OFS_W   = $clog2(BLOCK_W / 8);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RESP
    } l2_state_t;

endpackage

// File: rtl/l2_block_buffer.sv
// One-entry tag/valid store for the most recently completed block fill.
// Only compiled and used when L2_RESP_BUF_EN is defined.
`ifdef L2_RESP_BUF_EN
module l2_block_buffer #(
    parameter int unsigned TAG_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TAG_W-1:0] load_tag,
    input  logic             inval,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit
);

    logic [TAG_W-1:0] tag_q;
    logic             valid_q;

    // Tag register: load on completed fill, drop validity when the block data is overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            tag_q   <= load_tag;
            valid_q <= 1'b1;
        end else if (inval) begin
            valid_q <= 1'b0;
        end
    end

    // Hit when the held block matches the requested block address.
    always_comb begin
        hit = valid_q && (tag_q == lookup_tag);
    end

endmodule
`endif

// File: rtl/l2_ifetch_responder.sv
// L2-side responder for L1I block reads: fills a block from a word-wide memory
// port beat by beat, assembles it little-endian and presents it for one cycle.
// Optional feature macro: L2_RESP_BUF_EN (one-entry block buffer for repeat hits).
module l2_ifetch_responder #(
    parameter int unsigned ADDR_W  = l2_pkg::ADDR_W,
    parameter int unsigned BLOCK_W = l2_pkg::BLOCK_W,
    parameter int unsigned MEM_W   = l2_pkg::MEM_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               L2_read_en,
    input  logic [ADDR_W-1:0]  L2_addr_read,
    output logic [BLOCK_W-1:0] L2_block_read,
    output logic               L2_stall,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [MEM_W-1:0]   mem_rdata,
    input  logic               mem_valid
);

    import l2_pkg::*;

    localparam int unsigned NBEATS = BLOCK_W / MEM_W;
    localparam int unsigned BOFS_W = $clog2(BLOCK_W / 8);
    localparam int unsigned LANE_W = $clog2(MEM_W / 8);
    localparam int unsigned IDX_W  = BOFS_W - LANE_W;
    localparam int unsigned TAG_W  = ADDR_W - BOFS_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    l2_state_t          state_q, state_d;
    logic [TAG_W-1:0]   blk_q, blk_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               abort_q, abort_d;
    logic [BLOCK_W-1:0] block_q;
    logic [TAG_W-1:0]   req_blk;
    logic               wr_en;
    logic               buf_load;
    logic               buf_inval;
    logic               buf_hit;
    logic               redirect;
    logic               unused_ofs;

    assign req_blk    = L2_addr_read[ADDR_W-1:BOFS_W];
    assign unused_ofs = ^L2_addr_read[BOFS_W-1:0];

`ifdef L2_RESP_BUF_EN
    l2_block_buffer #(
        .TAG_W (TAG_W)
    ) u_block_buffer (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .load_tag   (blk_q),
        .inval      (buf_inval),
        .lookup_tag (req_blk),
        .hit        (buf_hit)
    );
`else
    logic unused_buf;
    assign buf_hit    = 1'b0;
    assign unused_buf = buf_load ^ buf_inval;
`endif

    // State, latched block address, beat index and abort flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            blk_q   <= '0;
            idx_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            idx_q   <= idx_d;
            abort_q <= abort_d;
        end
    end

    // Block assembler: each accepted beat lands in its little-endian word slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            block_q <= '0;
        end else if (wr_en) begin
            block_q[int'(idx_q) * MEM_W +: MEM_W] <= mem_rdata;
        end
    end

    // Next-state logic: accept, fill beat by beat (abortable), respond for one cycle.
    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        idx_d     = idx_q;
        abort_d   = abort_q;
        wr_en     = 1'b0;
        buf_load  = 1'b0;
        buf_inval = 1'b0;
        redirect  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (L2_read_en) begin
                    blk_d   = req_blk;
                    idx_d   = '0;
                    abort_d = 1'b0;
                    state_d = buf_hit ? RESP : FILL;
                end
            end
            FILL: begin
                redirect = !L2_read_en || (req_blk != blk_q);
                if (mem_valid) begin
                    if (abort_q || redirect) begin
                        // Outstanding beat has now completed; drop it and the partial block.
                        abort_d = 1'b0;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        wr_en = 1'b1;
                        // Buffered tag no longer describes the assembler once it is overwritten.
                        buf_inval = (idx_q == '0);
                        if (idx_q == LAST_IDX) begin
                            buf_load = 1'b1;
                            idx_d    = '0;
                            state_d  = RESP;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end else begin
                    abort_d = abort_q || redirect;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs derived from registered state only.
    always_comb begin
        L2_stall      = (state_q != RESP);
        mem_req       = (state_q == FILL);
        mem_addr      = {blk_q, idx_q, {LANE_W{1'b0}}};
        L2_block_read = block_q;
    end

endmodule
